mem_port_arbiter: RTL

//  Shares one single-port memory between two requesters. Port 0 is the multicycle CPU
//  (instruction fetch and load/store through its adr/writedata path). Port 1 is the

---
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester ports and memory port of the two-way memory arbiter
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              m0_req;
   logic              m0_we;
   logic [ADDR_W-1:0] m0_adr;
   logic [DATA_W-1:0] m0_wdata;
   logic [DATA_W-1:0] m0_rdata;
   logic              m0_ack;

   logic              m1_req;
   logic              m1_we;
   logic [ADDR_W-1:0] m1_adr;
   logic [DATA_W-1:0] m1_wdata;
   logic [DATA_W-1:0] m1_rdata;
   logic              m1_ack;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_adr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output m0_req, m0_we, m0_adr, m0_wdata,
      input  m0_rdata, m0_ack,
      output m1_req, m1_we, m1_adr, m1_wdata,
      input  m1_rdata, m1_ack,
      input  mem_en, mem_we, mem_adr, mem_wdata,
      output mem_rdata
   );

   modport slave (
      input  m0_req, m0_we, m0_adr, m0_wdata,
      output m0_rdata, m0_ack,
      input  m1_req, m1_we, m1_adr, m1_wdata,
      output m1_rdata, m1_ack,
      output mem_en, mem_we, mem_adr, mem_wdata,
      input  mem_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port arbiter in front of a single-port memory
// Fixed priority (port 0 wins ties) by default; define MEM_ARB_RR_EN for round-robin ties.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic             clk,
   input  logic             rst,
   mem_port_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              win_q, win_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] adr_q, adr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic              grant;

`ifdef MEM_ARB_RR_EN
   logic              rr_q, rr_d;

   // On a tie the port not granted last time wins; a lone request always wins.
   always_comb begin
      grant = bus.m1_req;
      if (bus.m0_req && bus.m1_req) begin
         grant = ~rr_q;
      end
   end
`else
   always_comb begin
      grant = ~bus.m0_req;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         win_q    <= 1'b0;
         we_q     <= 1'b0;
         adr_q    <= '0;
         wdata_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
`ifdef MEM_ARB_RR_EN
         rr_q     <= 1'b1;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         win_q    <= win_d;
         we_q     <= we_d;
         adr_q    <= adr_d;
         wdata_q  <= wdata_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
`ifdef MEM_ARB_RR_EN
         rr_q     <= rr_d;
`endif
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      win_d         = win_q;
      we_d          = we_q;
      adr_d         = adr_q;
      wdata_d       = wdata_q;
      rdata0_d      = rdata0_q;
      rdata1_d      = rdata1_q;
`ifdef MEM_ARB_RR_EN
      rr_d          = rr_q;
`endif
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_adr   = '0;
      bus.mem_wdata = '0;
      bus.m0_ack    = 1'b0;
      bus.m1_ack    = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.m0_req || bus.m1_req) begin
               win_d   = grant;
               we_d    = grant ? bus.m1_we    : bus.m0_we;
               adr_d   = grant ? bus.m1_adr   : bus.m0_adr;
               wdata_d = grant ? bus.m1_wdata : bus.m0_wdata;
               cnt_d   = CNT_LOAD;
               state_d = BUSY;
`ifdef MEM_ARB_RR_EN
               rr_d    = grant;
`endif
            end
         end
         BUSY: begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = we_q;
            bus.mem_adr   = adr_q;
            bus.mem_wdata = wdata_q;
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               // Last BUSY cycle: memory data is valid now, only the winner's register moves.
               if (!we_q) begin
                  if (win_q) begin
                     rdata1_d = bus.mem_rdata;
                  end else begin
                     rdata0_d = bus.mem_rdata;
                  end
               end
               state_d = RESP;
            end
         end
         RESP: begin
            bus.m0_ack = ~win_q;
            bus.m1_ack = win_q;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.m0_rdata = rdata0_q;
   assign bus.m1_rdata = rdata1_q;

endmodule
